// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared constants, state encoding and data helpers for the QPI PSRAM initiator
package psram_pkg;

  localparam logic [7:0] PSRAM_CMD_WR = 8'h38;
  localparam logic [7:0] PSRAM_CMD_RD = 8'hEB;
  localparam int         CMD_SCK      = 8;
  localparam int         ADDR_SCK     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_GAP,
    ST_RESP
  } psram_state_t;

  // Byte 0 ends up in the top byte so the quad shifter can emit MSB-first.
  function automatic logic [31:0] psram_byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Captured nibbles arrive first-byte-highest; place byte i at [8i+7:8i], zero the rest.
  function automatic logic [31:0] psram_pack_rdata(input logic [31:0] rx, input logic [1:0] len);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(len)) r[8*i +: 8] = rx[8*(int'(len) - i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/psram_qpi_shift.sv
// rtl/psram_qpi_shift.sv - nibble shift/capture unit: serial LSB-first or quad MSB-first transmit, quad receive
module psram_qpi_shift (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_load_quad,
  input  logic [31:0] i_load_data,
  input  logic        i_shift,
  input  logic        i_capture,
  input  logic [3:0]  i_dio_in,
  output logic [3:0]  o_dio_out,
  output logic [31:0] o_rx_data
);

  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        r_quad;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_quad <= 1'b0;
    end else begin
      if (i_load) begin
        r_tx   <= i_load_data;
        r_quad <= i_load_quad;
      end else if (i_shift) begin
        r_tx <= r_quad ? {r_tx[27:0], 4'h0} : {1'b0, r_tx[31:1]};
      end
      if (i_capture) r_rx <= {r_rx[27:0], i_dio_in};
    end
  end

  assign o_dio_out = r_quad ? r_tx[31:28] : {3'b000, r_tx[0]};
  assign o_rx_data = r_rx;

endmodule

// File: rtl/psram_qpi_ctrl.sv
// rtl/psram_qpi_ctrl.sv - QPI PSRAM initiator: one request becomes one cmd/addr/data transaction
module psram_qpi_ctrl
  import psram_pkg::*;
#(
  parameter int CE_GAP = 2,
  parameter int ADDR_W = 24
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_len,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_rdata,
  output logic              o_psram_sck,
  output logic              o_psram_ce_n,
  output logic [3:0]        o_psram_dio_out,
  output logic [3:0]        o_psram_dio_oe,
  input  logic [3:0]        i_psram_dio_in
);

  psram_state_t      r_state;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_len;
  logic [31:0]       r_wdata;
  logic [7:0]        r_cnt;
  logic              r_sck;
  logic              r_ce_n;
  logic [3:0]        r_oe;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;

  logic [7:0]        w_last;
  logic              w_active;
  logic              w_slot_end;
  logic              w_load;
  logic              w_load_quad;
  logic [31:0]       w_load_data;
  logic [31:0]       w_rx;

  assign w_active   = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                      (r_state == ST_WDATA) || (r_state == ST_RDATA);
  assign w_slot_end = w_active && r_sck && (r_cnt == w_last);

  always_comb begin
    w_last = 8'd0;
    case (r_state)
      ST_CMD:  w_last = 8'(CMD_SCK - 1);
      ST_ADDR: w_last = 8'(ADDR_SCK - 1);
      default: w_last = {5'd0, r_len, 1'b1};
    endcase
  end

  // New phase data is loaded on the sck falling edge that ends the previous phase.
  always_comb begin
    w_load      = 1'b0;
    w_load_quad = 1'b0;
    w_load_data = '0;
    if (r_state == ST_IDLE && i_req_valid) begin
      w_load      = 1'b1;
      w_load_data = {24'd0, i_req_write ? PSRAM_CMD_WR : PSRAM_CMD_RD};
    end else if (w_slot_end) begin
      w_load = 1'b1;
      if (r_state == ST_CMD) begin
        w_load_quad = 1'b1;
        w_load_data = {24'(r_addr), 8'd0};
      end else if (r_state == ST_ADDR && r_write) begin
        w_load_quad = 1'b1;
        w_load_data = psram_byte_swap(r_wdata);
      end
    end
  end

  psram_qpi_shift u_shift (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_load_quad (w_load_quad),
    .i_load_data (w_load_data),
    .i_shift     (w_active && r_sck && !w_slot_end),
    .i_capture   ((r_state == ST_RDATA) && !r_sck),
    .i_dio_in    (i_psram_dio_in),
    .o_dio_out   (o_psram_dio_out),
    .o_rx_data   (w_rx)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_sck        <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe         <= 4'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_write     <= i_req_write;
            r_addr      <= i_req_addr;
            r_len       <= i_req_len;
            r_wdata     <= i_req_wdata;
            r_cnt       <= '0;
            r_sck       <= 1'b0;
            r_ce_n      <= 1'b0;
            r_oe        <= 4'b0001;
            r_req_ready <= 1'b0;
            r_state     <= ST_CMD;
          end
        end
        ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA: begin
          r_sck <= ~r_sck;
          if (r_sck) begin
            if (r_cnt == w_last) begin
              r_cnt <= '0;
              case (r_state)
                ST_CMD: begin
                  r_state <= ST_ADDR;
                  r_oe    <= 4'b1111;
                end
                ST_ADDR: begin
                  r_state <= r_write ? ST_WDATA : ST_RDATA;
                  r_oe    <= r_write ? 4'b1111 : 4'b0000;
                end
                default: begin
                  r_state <= ST_GAP;
                  r_ce_n  <= 1'b1;
                  r_oe    <= 4'b0000;
                end
              endcase
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (r_cnt == 8'(CE_GAP - 1)) begin
            r_cnt        <= '0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? 32'd0 : psram_pack_rdata(w_rx, r_len);
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_rdata   = r_resp_rdata;
  assign o_psram_sck    = r_sck;
  assign o_psram_ce_n   = r_ce_n;
  assign o_psram_dio_oe = r_oe;

endmodule

// File: doc/psram_qpi_ctrl.md
Name: psram_qpi_ctrl

Overview:
- Initiator side of the on-board QPI PSRAM link.
- Accepts single byte-to-word read/write requests on a simple valid/ready port and converts each into one QPI transaction: command, address, data.
- Generates psram_sck, psram_ce_n and the dio nibble bus toward the PSRAM device model.
- Sits between the SoC bus adapter and the psram pad tri-state.

Parameters:
- CE_GAP, 2, minimum clock cycles psram_ce_n stays high between transactions (>=1).
- ADDR_W, 24, request/QPI address width; only bits [21:0] are significant to the 4 MiB device.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write (cmd 0x38), 0 = read (cmd 0xEB).
- req_addr  in  ADDR_W  byte address of first byte.
- req_len  in  2  byte count minus 1 (0..3 -> 1..4 bytes).
- req_wdata  in  32  write data; byte i at [8i+7:8i] goes to addr+i.
- resp_valid  out  1  transaction complete; held until resp_ready.
- resp_ready  in  1  response consumer ready.
- resp_rdata  out  32  read data; byte i at [8i+7:8i]; unused bytes 0; 0 after writes.
- psram_sck  out  1  QPI clock, clock/2.
- psram_ce_n  out  1  chip enable, active low.
- psram_dio_out  out  4  nibble driven to device.
- psram_dio_oe  out  4  per-bit output enable (all equal).
- psram_dio_in  in  4  nibble sampled from device.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, psram_sck=0, psram_ce_n=1, psram_dio_out=0, psram_dio_oe=0. Reset mid-transaction aborts immediately to IDLE; no response is produced.
- Each QPI bit slot is 2 clocks: a low phase (controller updates dio_out) followed by a high phase. The device samples on the sck rising edge.
- Read sampling: the controller registers psram_dio_in on the clock edge that raises sck, capturing the value stable during the low phase.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, GAP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields, assert ce_n low and sck low, and drive cmd bit0; go to CMD.
- CMD:
  - 8 sck periods, serial on dio[0], LSB first (bit0 on first sck). dio_oe=4'b0001 (bits 3:1 driven 0 or not driven; oe for bit0 is mandatory).
- ADDR:
  - 6 sck periods, dio_oe=4'b1111, address nibbles MSB-first: addr[23:20] first, addr[3:0] last.
- WDATA:
  - 2 sck periods per byte, high nibble then low nibble.
  - Bytes are sent in order addr+0..addr+len; the device auto-increments.
- RDATA:
  - dio_oe=0 from the low phase after the last address rising edge. No dummy cycles.
  - 2 sck periods per byte; the first rising edge captures the high nibble of byte 0.
  - Captured bytes are assembled into resp_rdata.
- End of transaction: after the last data rising edge, the next clock drives sck=0, ce_n=1, oe=0 and enters GAP.
- GAP: ce_n held high for CE_GAP clocks, then go to RESP.
- RESP:
  - resp_valid=1 until resp_ready; then return to IDLE.
  - A new request may be accepted in the cycle after the handshake.
- ce_n low duration is exactly 2*(14+2*(len+1)) clocks, e.g. 44 clocks for a 4-byte access.
- sck is never high while ce_n is high.
- Address arithmetic is left to the device; the controller does not detect wrap at the 4 MiB boundary (device index wraps modulo 2^22).
- req_len beyond the remaining bytes of the word is legal; it is not range-checked.

Decomposition:
- Package psram_pkg:
  - PSRAM_CMD_WR=8'h38, PSRAM_CMD_RD=8'hEB.
  - State enum.
  - Phase lengths: CMD_SCK=8, ADDR_SCK=6.
- One natural sub-module, psram_qpi_shift: a nibble shift/capture unit with serial/quad modes that the FSM sequences via a slot counter.

Test Plan:
- Write 4 bytes addr=0x000100, wdata=0xDDCCBBAA.
  - dio[0] shows 0x38 LSB-first, then nibbles 0,0,0,1,0,0, then A,A,B,B,C,C,D,D.
  - ce_n low 44 clocks; resp_valid with rdata=0.
- Read back addr=0x000100 len=3 from the device model -> resp_rdata=0xDDCCBBAA.
  - oe drops right after address; command 0xEB observed.
- Read addr=0x000102 len=0 -> resp_rdata=0x000000CC; ce_n low 32 clocks.
- Back-to-back writes with resp_ready tied 1.
  - ce_n high >= CE_GAP clocks between transactions.
  - req_ready=0 throughout the first transaction.
- Assert reset during the ADDR phase.
  - Outputs return to reset values asynchronously; no resp_valid.
  - A subsequent read of 0x000100 returns the prior data 0xDDCCBBAA.
- Hold resp_ready=0 for 10 cycles.
  - resp_valid and resp_rdata stay stable; req_ready=0; no new ce_n activity.
